// File: rtl/contador_bcd.sv
// Two-digit BCD up/down counter with built-in prescaler, load/clear and carry/tick chaining outputs.
// Optional leading-zero blank output enabled by defining CONTADOR_ZERO_BLANK_EN.
module contador_bcd #(
    parameter int DIV       = 50000000,
    parameter int MAX_COUNT = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       up_down,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [3:0] bcd_units,
    output logic [3:0] bcd_tens,
    output logic       tick,
    output logic       carry,
    output logic       load_err,
`ifdef CONTADOR_ZERO_BLANK_EN
    output logic       display_on,
    output logic       tens_blank
`else
    output logic       display_on
`endif
);

    localparam int             PW         = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [3:0]     MAX_TENS   = 4'(MAX_COUNT / 10);
    localparam logic [3:0]     MAX_UNITS  = 4'(MAX_COUNT % 10);

    logic [PW-1:0] prescaler;
    logic [PW-1:0] next_prescaler;
    logic [3:0]    next_units;
    logic [3:0]    next_tens;
    logic          next_tick;
    logic          next_carry;
    logic          next_load_err;

    logic [3:0]    load_units;
    logic [3:0]    load_tens;
    logic          load_ok;

    logic [3:0]    step_units;
    logic [3:0]    step_tens;
    logic          step_wrap;
    logic          at_max;
    logic          at_zero;

    assign load_units = load_value[3:0];
    assign load_tens  = load_value[7:4];
    assign at_max     = (bcd_tens == MAX_TENS) && (bcd_units == MAX_UNITS);
    assign at_zero    = (bcd_tens == 4'd0) && (bcd_units == 4'd0);

    // A load is only legal if both nibbles are decimal digits and the value fits under the terminal count.
    always_comb begin
        load_ok = (load_units <= 4'd9) && (load_tens <= 4'd9) &&
                  ((load_tens < MAX_TENS) ||
                   ((load_tens == MAX_TENS) && (load_units <= MAX_UNITS)));
    end

    always_comb begin
        step_units = bcd_units;
        step_tens  = bcd_tens;
        step_wrap  = 1'b0;
        if (up_down) begin
            if (at_max) begin
                step_units = 4'd0;
                step_tens  = 4'd0;
                step_wrap  = 1'b1;
            end else if (bcd_units == 4'd9) begin
                step_units = 4'd0;
                step_tens  = bcd_tens + 4'd1;
            end else begin
                step_units = bcd_units + 4'd1;
            end
        end else begin
            if (at_zero) begin
                step_units = MAX_UNITS;
                step_tens  = MAX_TENS;
                step_wrap  = 1'b1;
            end else if (bcd_units == 4'd0) begin
                step_units = 4'd9;
                step_tens  = bcd_tens - 4'd1;
            end else begin
                step_units = bcd_units - 4'd1;
            end
        end
    end

    // Clear beats load, load beats the tick step; a tick already raised still steps even if enable just dropped.
    always_comb begin
        next_prescaler = prescaler;
        next_units     = bcd_units;
        next_tens      = bcd_tens;
        next_tick      = 1'b0;
        next_carry     = 1'b0;
        next_load_err  = 1'b0;
        if (clear) begin
            next_prescaler = '0;
            next_units     = 4'd0;
            next_tens      = 4'd0;
        end else begin
            if (enable) begin
                if (prescaler == PRESC_LAST) begin
                    next_prescaler = '0;
                    next_tick      = 1'b1;
                end else begin
                    next_prescaler = prescaler + PW'(1);
                end
            end
            if (load) begin
                if (load_ok) begin
                    next_units     = load_units;
                    next_tens      = load_tens;
                    next_prescaler = '0;
                    next_tick      = 1'b0;
                end else begin
                    next_load_err  = 1'b1;
                end
            end else if (tick) begin
                next_units = step_units;
                next_tens  = step_tens;
                next_carry = step_wrap;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            bcd_units  <= 4'd0;
            bcd_tens   <= 4'd0;
            tick       <= 1'b0;
            carry      <= 1'b0;
            load_err   <= 1'b0;
            display_on <= 1'b0;
`ifdef CONTADOR_ZERO_BLANK_EN
            tens_blank <= 1'b0;
`endif
        end else begin
            prescaler  <= next_prescaler;
            bcd_units  <= next_units;
            bcd_tens   <= next_tens;
            tick       <= next_tick;
            carry      <= next_carry;
            load_err   <= next_load_err;
            display_on <= 1'b1;
`ifdef CONTADOR_ZERO_BLANK_EN
            tens_blank <= (next_tens == 4'd0);
`endif
        end
    end

endmodule

// File: tb/tb_contador_bcd.sv
// Directed self-checking bench for contador_bcd: one instance with MAX_COUNT=99, one with MAX_COUNT=59, both DIV=4.
// Covers the CONTADOR_ZERO_BLANK_EN output when that macro is defined.
module tb_contador_bcd;

    logic       clk;
    logic       reset;

    logic       enable, up_down, clear, load;
    logic [7:0] load_value;
    logic [3:0] bcd_units, bcd_tens;
    logic       tick, carry, load_err, display_on;

    logic       e59, ud59, clr59, ld59;
    logic [7:0] lv59;
    logic [3:0] units59, tens59;
    logic       tick59, carry59, err59, disp59;

`ifdef CONTADOR_ZERO_BLANK_EN
    logic       tens_blank, tens_blank59;
`endif

    int vectors;
    int miscompares;

    contador_bcd #(.DIV(4), .MAX_COUNT(99)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .bcd_units(bcd_units), .bcd_tens(bcd_tens), .tick(tick),
        .carry(carry), .load_err(load_err),
`ifdef CONTADOR_ZERO_BLANK_EN
        .tens_blank(tens_blank),
`endif
        .display_on(display_on)
    );

    contador_bcd #(.DIV(4), .MAX_COUNT(59)) dut59 (
        .clk(clk), .reset(reset), .enable(e59), .up_down(ud59),
        .clear(clr59), .load(ld59), .load_value(lv59),
        .bcd_units(units59), .bcd_tens(tens59), .tick(tick59),
        .carry(carry59), .load_err(err59),
`ifdef CONTADOR_ZERO_BLANK_EN
        .tens_blank(tens_blank59),
`endif
        .display_on(disp59)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name, input logic [7:0] exp_bcd, input logic exp_carry);
        vectors++;
        if ({bcd_tens, bcd_units, carry} !== {exp_bcd, exp_carry}) begin
            miscompares++;
            $display("[TB] FAIL %s: got count=%h carry=%b, expected count=%h carry=%b",
                     name, {bcd_tens, bcd_units}, carry, exp_bcd, exp_carry);
        end
    endtask

    task automatic wait_tick(input string name);
        for (int i = 0; i < 8 && tick !== 1'b1; i++) step();
        vectors++;
        if (tick !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s: tick never seen, got tick=%b expected 1", name, tick);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({bcd_tens, bcd_units, tick, carry, load_err, display_on} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h, expected 000",
                     {bcd_tens, bcd_units, tick, carry, load_err, display_on});
        end
        step();
        vectors++;
        if (display_on !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_display: got display_on=%b, expected 0", display_on);
        end
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        int cnt;
        logic [10:0] expv;
        for (int s = 1; s <= 405; s++) begin
            step();
            cnt  = ((s - 1) / 4) % 100;
            expv = {4'(cnt / 10), 4'(cnt % 10), (s % 4 == 0),
                    (s >= 5) && ((s - 1) % 4 == 0) && (cnt == 0), 1'b1};
            vectors++;
            if ({bcd_tens, bcd_units, tick, carry, display_on} !== expv) begin
                miscompares++;
                $display("[TB] FAIL count_up step %0d: got %h, expected %h", s,
                         {bcd_tens, bcd_units, tick, carry, display_on}, expv);
            end
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_value = 8'h37;
        step();
        load = 1'b0;
        check_count("load_37", 8'h37, 1'b0);
        vectors++;
        if (load_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_37_err: got %b, expected 0", load_err);
        end
        load = 1'b1; load_value = 8'h3A;
        step();
        load = 1'b0;
        check_count("load_3A_hold", 8'h37, 1'b0);
        vectors++;
        if (load_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL load_3A_err: got %b, expected 1", load_err);
        end
        step();
        vectors++;
        if (load_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_err_pulse: got %b, expected 0", load_err);
        end
    endtask

    task automatic test_priority();
        load = 1'b1; load_value = 8'h99;
        step();
        load = 1'b0;
        wait_tick("prio_wait1");
        clear = 1'b1; load = 1'b1; load_value = 8'h55;
        step();
        clear = 1'b0; load = 1'b0;
        check_count("clear_load_tick", 8'h00, 1'b0);
        load = 1'b1; load_value = 8'h99;
        step();
        load = 1'b0;
        wait_tick("prio_wait2");
        load = 1'b1; load_value = 8'h21;
        step();
        load = 1'b0;
        check_count("load_tick", 8'h21, 1'b0);
        step();
        check_count("load_tick_nostep", 8'h21, 1'b0);
    endtask

    task automatic test_hold();
        step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({bcd_tens, bcd_units, tick} !== {8'h21, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL hold cycle %0d: got count=%h tick=%b, expected 21 tick=0",
                         i, {bcd_tens, bcd_units}, tick);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({bcd_tens, bcd_units, tick} !== {(i == 2) ? 8'h22 : 8'h21, (i == 1)}) begin
                miscompares++;
                $display("[TB] FAIL resume cycle %0d: got count=%h tick=%b", i,
                         {bcd_tens, bcd_units}, tick);
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [9:0] expv;
        e59 = 1'b1; ud59 = 1'b0; ld59 = 1'b1; lv59 = 8'h00;
        step();
        ld59 = 1'b0;
        for (int s = 1; s <= 9; s++) begin
            if (s == 6) begin
                ld59 = 1'b1; lv59 = 8'h75;
            end
            step();
            ld59 = 1'b0;
            expv = {(s >= 9) ? 8'h58 : ((s >= 5) ? 8'h59 : 8'h00), (s == 5), (s == 6)};
            vectors++;
            if ({tens59, units59, carry59, err59} !== expv) begin
                miscompares++;
                $display("[TB] FAIL down_wrap step %0d: got count=%h carry=%b err=%b, expected %h",
                         s, {tens59, units59}, carry59, err59, expv);
            end
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_value = 8'h42;
        step();
        load = 1'b0;
        check_count("pre_reset_42", 8'h42, 1'b0);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bcd_tens, bcd_units, tick, carry, load_err, display_on} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h, expected 000",
                     {bcd_tens, bcd_units, tick, carry, load_err, display_on});
        end
`ifdef CONTADOR_ZERO_BLANK_EN
        vectors++;
        if (tens_blank !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL blank_reset: got %b, expected 0", tens_blank);
        end
`endif
        step();
        reset = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            step();
            vectors++;
            if ({bcd_tens, bcd_units, tick, display_on} !== {8'h00, (s == 4), 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL post_reset step %0d: got count=%h tick=%b disp=%b", s,
                         {bcd_tens, bcd_units}, tick, display_on);
            end
        end
    endtask

`ifdef CONTADOR_ZERO_BLANK_EN
    task automatic test_zero_blank();
        load = 1'b1; load_value = 8'h07;
        step();
        vectors++;
        if (tens_blank !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL blank_07: got %b, expected 1", tens_blank);
        end
        load_value = 8'h17;
        step();
        load = 1'b0;
        vectors++;
        if (tens_blank !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL blank_17: got %b, expected 0", tens_blank);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        enable = 1'b1; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_value = 8'h00;
        e59 = 1'b0; ud59 = 1'b1; clr59 = 1'b0; ld59 = 1'b0; lv59 = 8'h00;
        test_reset();
        test_count_up();
        test_load();
        test_priority();
        test_hold();
        test_down_wrap();
        test_async_reset();
`ifdef CONTADOR_ZERO_BLANK_EN
        test_zero_blank();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
